// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI command sequencer and its sub-blocks.
package spi_ctrl_pkg;

  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;
  localparam int CMD_RD_BIT = 7;

  localparam logic [DATA_W-1:0] ID_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    S_BOOT,
    S_CMD,
    S_WRITE,
    S_RD_REQ,
    S_RD_LOAD,
    S_READ
  } state_e;

endpackage

// File: rtl/cs_sync.sv
// Two-flop synchroniser for the raw chip-select pin plus a rising-edge pulse.
// All flops reset high so an idle (high) pin produces no edge at reset release.
module cs_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic cs_n_i,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= cs_n_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// Decodes chip-select framed SPI byte streams into parameter register writes and
// reads with address auto-increment, and preloads the slave's MISO byte.
module spi_reg_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter logic [DATA_W-1:0] ID_BYTE = ID_BYTE_DEFAULT
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic              i_RX_DV,
  input  logic [DATA_W-1:0] i_RX_Byte,
  input  logic              i_SPI_CS_n,
  output logic              o_TX_DV,
  output logic [DATA_W-1:0] o_TX_Byte,
  output logic              o_Wr_En,
  output logic              o_Rd_En,
  output logic [ADDR_W-1:0] o_Addr,
  output logic [DATA_W-1:0] o_Wr_Data,
  input  logic [DATA_W-1:0] i_Rd_Data,
  output logic              o_Frame_Done
);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              tx_dv_q;
  logic [DATA_W-1:0] tx_byte_q;
  logic              wr_en_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] addr_out_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              frame_done_q;
  logic              cs_rise;
  logic              wr_fire;

  cs_sync u_cs_sync (
    .clk_i  (i_Clk),
    .rst_ni (i_Rst_L),
    .cs_n_i (i_SPI_CS_n),
    .rise_o (cs_rise)
  );

  // A data byte arriving together with the frame end still gets written.
  assign wr_fire = (state_q == S_WRITE) && i_RX_DV;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q      <= S_BOOT;
      addr_q       <= '0;
      tx_dv_q      <= 1'b0;
      tx_byte_q    <= '0;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      addr_out_q   <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      tx_dv_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      frame_done_q <= 1'b0;

      if (wr_fire) begin
        wr_en_q    <= 1'b1;
        addr_out_q <= addr_q;
        wr_data_q  <= i_RX_Byte;
        addr_q     <= addr_q + ADDR_W'(1);
      end

      if (cs_rise) begin
        frame_done_q <= 1'b1;
        state_q      <= S_BOOT;
      end else begin
        case (state_q)
          S_BOOT: begin
            tx_dv_q   <= 1'b1;
            tx_byte_q <= ID_BYTE;
            state_q   <= S_CMD;
          end
          S_CMD: begin
            if (i_RX_DV) begin
              addr_q  <= i_RX_Byte[ADDR_W-1:0];
              state_q <= i_RX_Byte[CMD_RD_BIT] ? S_RD_REQ : S_WRITE;
            end
          end
          S_WRITE: begin
            state_q <= S_WRITE;
          end
          // Bytes arriving during the request/load pair are ignored.
          S_RD_REQ: begin
            rd_en_q    <= 1'b1;
            addr_out_q <= addr_q;
            state_q    <= S_RD_LOAD;
          end
          S_RD_LOAD: begin
            tx_dv_q   <= 1'b1;
            tx_byte_q <= i_Rd_Data;
            addr_q    <= addr_q + ADDR_W'(1);
            state_q   <= S_READ;
          end
          S_READ: begin
            if (i_RX_DV) begin
              state_q <= S_RD_REQ;
            end
          end
          default: begin
            state_q <= S_BOOT;
          end
        endcase
      end
    end
  end

  assign o_TX_DV      = tx_dv_q;
  assign o_TX_Byte    = tx_byte_q;
  assign o_Wr_En      = wr_en_q;
  assign o_Rd_En      = rd_en_q;
  assign o_Addr       = addr_out_q;
  assign o_Wr_Data    = wr_data_q;
  assign o_Frame_Done = frame_done_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed self-checking bench for spi_reg_ctrl: logs every strobe with its cycle
// number and compares the logs against hand-computed transactions per scenario.
module tb_spi_reg_ctrl;

  typedef struct {
    int         cyc;
    logic [6:0] addr;
    logic [7:0] data;
  } event_t;

  logic       clock;
  logic       rstL;
  logic       rxDv;
  logic [7:0] rxByte;
  logic       csN;
  logic       txDv;
  logic [7:0] txByte;
  logic       wrEn;
  logic       rdEn;
  logic [6:0] addr;
  logic [7:0] wrData;
  logic [7:0] rdData;
  logic       frameDone;

  int cyc = 0;
  int testsRun = 0;
  int testsFailed = 0;

  event_t wrLog[$];
  event_t rdLog[$];
  event_t txLog[$];
  int     doneLog[$];

  spi_reg_ctrl dut (
    .i_Clk        (clock),
    .i_Rst_L      (rstL),
    .i_RX_DV      (rxDv),
    .i_RX_Byte    (rxByte),
    .i_SPI_CS_n   (csN),
    .o_TX_DV      (txDv),
    .o_TX_Byte    (txByte),
    .o_Wr_En      (wrEn),
    .o_Rd_En      (rdEn),
    .o_Addr       (addr),
    .o_Wr_Data    (wrData),
    .i_Rd_Data    (rdData),
    .o_Frame_Done (frameDone)
  );

  // Register file model: read data is address + 0x40, following the address bus.
  assign rdData = {1'b0, addr} + 8'h40;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Strobe monitor samples on the falling edge, away from the active edge.
  always @(negedge clock) begin
    event_t e;
    e.cyc = cyc;
    e.addr = addr;
    e.data = wrData;
    if (wrEn) wrLog.push_back(e);
    if (rdEn) rdLog.push_back(e);
    e.addr = 7'd0;
    e.data = txByte;
    if (txDv) txLog.push_back(e);
    if (frameDone) doneLog.push_back(cyc);
  end

  task automatic clearLogs();
    wrLog.delete();
    rdLog.delete();
    txLog.delete();
    doneLog.delete();
  endtask

  // Byte pulse followed by a generous inter-byte gap; returns the issue cycle.
  task automatic sendByte(input logic [7:0] b, output int c);
    rxByte = b;
    rxDv = 1'b1;
    c = cyc;
    @(negedge clock);
    rxDv = 1'b0;
    repeat (9) @(negedge clock);
  endtask

  task automatic startFrame();
    csN = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic endFrame(output int c);
    csN = 1'b1;
    c = cyc;
    repeat (10) @(negedge clock);
  endtask

  // Common frame-end check: one done pulse 3 cycles after the pin rise, one ID load after it.
  task automatic checkFrameEnd(input string name, input int ce, input int txIdx);
    testsRun++;
    if (doneLog.size() != 1 || (doneLog.size() == 1 && doneLog[0] != ce + 3)) begin
      testsFailed++;
      $display("[TB] FAIL %s_done: got %0d pulses (first cyc %0d) expected 1 at cyc %0d",
               name, doneLog.size(), (doneLog.size() > 0) ? doneLog[0] : -1, ce + 3);
    end
    testsRun++;
    if (txLog.size() != txIdx + 1) begin
      testsFailed++;
      $display("[TB] FAIL %s_txcount: got %0d loads expected %0d", name, txLog.size(), txIdx + 1);
    end else if (txLog[txIdx].data !== 8'hA5 || txLog[txIdx].cyc != ce + 4) begin
      testsFailed++;
      $display("[TB] FAIL %s_idload: got %h at cyc %0d expected a5 at cyc %0d",
               name, txLog[txIdx].data, txLog[txIdx].cyc, ce + 4);
    end
  endtask

  task automatic test_reset();
    int rc;
    rstL = 1'b0;
    csN = 1'b1;
    rxDv = 1'b0;
    rxByte = 8'h00;
    repeat (3) @(negedge clock);
    testsRun++;
    if ({txDv, wrEn, rdEn, frameDone, txByte, addr, wrData} !== 27'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: got %b expected all zero",
               {txDv, wrEn, rdEn, frameDone, txByte, addr, wrData});
    end
    clearLogs();
    rstL = 1'b1;
    rc = cyc;
    repeat (8) @(negedge clock);
    testsRun++;
    if (txLog.size() != 1) begin
      testsFailed++;
      $display("[TB] FAIL reset_txcount: got %0d loads expected 1", txLog.size());
    end else if (txLog[0].data !== 8'hA5 || txLog[0].cyc != rc + 1) begin
      testsFailed++;
      $display("[TB] FAIL reset_idload: got %h at cyc %0d expected a5 at cyc %0d",
               txLog[0].data, txLog[0].cyc, rc + 1);
    end
    testsRun++;
    if (wrLog.size() != 0 || rdLog.size() != 0 || doneLog.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL reset_strobes: got wr=%0d rd=%0d done=%0d expected 0 0 0",
               wrLog.size(), rdLog.size(), doneLog.size());
    end
  endtask

  task automatic test_write();
    int c0, c1, c2, ce;
    clearLogs();
    startFrame();
    sendByte(8'h05, c0);
    sendByte(8'h11, c1);
    sendByte(8'h22, c2);
    endFrame(ce);
    testsRun++;
    if (wrLog.size() != 2) begin
      testsFailed++;
      $display("[TB] FAIL write_count: got %0d writes expected 2", wrLog.size());
    end else begin
      if (wrLog[0].addr !== 7'h05 || wrLog[0].data !== 8'h11 || wrLog[0].cyc != c1 + 1) begin
        testsFailed++;
        $display("[TB] FAIL write_first: got a=%h d=%h cyc %0d expected a=05 d=11 cyc %0d",
                 wrLog[0].addr, wrLog[0].data, wrLog[0].cyc, c1 + 1);
      end
      testsRun++;
      if (wrLog[1].addr !== 7'h06 || wrLog[1].data !== 8'h22 || wrLog[1].cyc != c2 + 1) begin
        testsFailed++;
        $display("[TB] FAIL write_second: got a=%h d=%h cyc %0d expected a=06 d=22 cyc %0d",
                 wrLog[1].addr, wrLog[1].data, wrLog[1].cyc, c2 + 1);
      end
    end
    testsRun++;
    if (rdLog.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL write_noread: got %0d reads expected 0", rdLog.size());
    end
    checkFrameEnd("write", ce, 0);
    if (c0 < 0) $display("[TB] note: bad cycle stamp");
  endtask

  task automatic test_read();
    int c[3];
    int ce;
    logic [7:0] cmd[3];
    clearLogs();
    startFrame();
    cmd[0] = 8'h83;
    cmd[1] = 8'h00;
    cmd[2] = 8'hFF;
    for (int i = 0; i < 3; i++) sendByte(cmd[i], c[i]);
    endFrame(ce);
    testsRun++;
    if (rdLog.size() != 3) begin
      testsFailed++;
      $display("[TB] FAIL read_count: got %0d reads expected 3", rdLog.size());
    end
    for (int i = 0; i < 3; i++) begin
      if (i < rdLog.size()) begin
        testsRun++;
        if (rdLog[i].addr !== 7'(3 + i) || rdLog[i].cyc != c[i] + 2) begin
          testsFailed++;
          $display("[TB] FAIL read_strobe%0d: got a=%h cyc %0d expected a=%h cyc %0d",
                   i, rdLog[i].addr, rdLog[i].cyc, 7'(3 + i), c[i] + 2);
        end
      end
      if (i < txLog.size()) begin
        testsRun++;
        if (txLog[i].data !== 8'(8'h43 + i) || txLog[i].cyc != c[i] + 3) begin
          testsFailed++;
          $display("[TB] FAIL read_tx%0d: got %h cyc %0d expected %h cyc %0d",
                   i, txLog[i].data, txLog[i].cyc, 8'(8'h43 + i), c[i] + 3);
        end
      end
    end
    testsRun++;
    if (wrLog.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL read_nowrite: got %0d writes expected 0", wrLog.size());
    end
    checkFrameEnd("read", ce, 3);
  endtask

  task automatic test_wrap();
    int c0, c1, c2, ce;
    clearLogs();
    startFrame();
    sendByte(8'h7F, c0);
    sendByte(8'hAA, c1);
    sendByte(8'hBB, c2);
    endFrame(ce);
    testsRun++;
    if (wrLog.size() != 2) begin
      testsFailed++;
      $display("[TB] FAIL wrap_count: got %0d writes expected 2", wrLog.size());
    end else if (wrLog[0].addr !== 7'h7F || wrLog[0].data !== 8'hAA ||
                 wrLog[1].addr !== 7'h00 || wrLog[1].data !== 8'hBB) begin
      testsFailed++;
      $display("[TB] FAIL wrap_addr: got %h/%h %h/%h expected 7f/aa 00/bb",
               wrLog[0].addr, wrLog[0].data, wrLog[1].addr, wrLog[1].data);
    end
    checkFrameEnd("wrap", ce, 0);
  endtask

  task automatic test_cmd_only();
    int c0, ce;
    clearLogs();
    startFrame();
    sendByte(8'h20, c0);
    endFrame(ce);
    testsRun++;
    if (wrLog.size() != 0 || rdLog.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL cmdonly_write: got wr=%0d rd=%0d expected 0 0", wrLog.size(), rdLog.size());
    end
    clearLogs();
    startFrame();
    sendByte(8'hA0, c0);
    endFrame(ce);
    testsRun++;
    if (rdLog.size() != 1 || (rdLog.size() == 1 && rdLog[0].addr !== 7'h20)) begin
      testsFailed++;
      $display("[TB] FAIL cmdonly_read: got %0d reads expected 1 at addr 20", rdLog.size());
    end
    testsRun++;
    if (txLog.size() < 1 || txLog[0].data !== 8'h60 || txLog[0].cyc != c0 + 3) begin
      testsFailed++;
      $display("[TB] FAIL cmdonly_tx: got %0d loads expected 60 at cyc %0d", txLog.size(), c0 + 3);
    end
    checkFrameEnd("cmdonly", ce, 1);
  endtask

  task automatic test_back_to_back();
    int c0, c1, ce;
    clearLogs();
    startFrame();
    sendByte(8'h10, c0);
    sendByte(8'h33, c1);
    // Last byte lands in the exact cycle the synchronised edge is seen.
    csN = 1'b1;
    ce = cyc;
    repeat (2) @(negedge clock);
    rxByte = 8'h77;
    rxDv = 1'b1;
    @(negedge clock);
    rxDv = 1'b0;
    repeat (8) @(negedge clock);
    testsRun++;
    if (wrLog.size() != 2) begin
      testsFailed++;
      $display("[TB] FAIL coincident_count: got %0d writes expected 2", wrLog.size());
    end else if (wrLog[1].addr !== 7'h11 || wrLog[1].data !== 8'h77 || wrLog[1].cyc != ce + 3) begin
      testsFailed++;
      $display("[TB] FAIL coincident_write: got a=%h d=%h cyc %0d expected a=11 d=77 cyc %0d",
               wrLog[1].addr, wrLog[1].data, wrLog[1].cyc, ce + 3);
    end
    checkFrameEnd("coincident", ce, 0);
    clearLogs();
    startFrame();
    sendByte(8'h01, c0);
    sendByte(8'h55, c1);
    endFrame(ce);
    testsRun++;
    if (wrLog.size() != 1 || (wrLog.size() == 1 && (wrLog[0].addr !== 7'h01 || wrLog[0].data !== 8'h55))) begin
      testsFailed++;
      $display("[TB] FAIL nextframe_write: got %0d writes expected one a=01 d=55", wrLog.size());
    end
  endtask

  task automatic test_async_reset();
    int rc;
    clearLogs();
    startFrame();
    rxByte = 8'h90;
    rxDv = 1'b1;
    @(negedge clock);
    rxDv = 1'b0;
    @(negedge clock);
    testsRun++;
    if (rdEn !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL areset_setup: got rd_en=%b expected 1", rdEn);
    end
    // Reset lands mid-cycle while the FSM sits in the load state.
    rstL = 1'b0;
    csN = 1'b1;
    #1;
    testsRun++;
    if ({txDv, wrEn, rdEn, frameDone, txByte, addr, wrData} !== 27'd0) begin
      testsFailed++;
      $display("[TB] FAIL areset_outputs: got %b expected all zero",
               {txDv, wrEn, rdEn, frameDone, txByte, addr, wrData});
    end
    clearLogs();
    repeat (3) @(negedge clock);
    rstL = 1'b1;
    rc = cyc;
    repeat (10) @(negedge clock);
    testsRun++;
    if (txLog.size() != 1 || (txLog.size() == 1 && (txLog[0].data !== 8'hA5 || txLog[0].cyc != rc + 1))) begin
      testsFailed++;
      $display("[TB] FAIL areset_reload: got %0d loads expected one a5 at cyc %0d", txLog.size(), rc + 1);
    end
    testsRun++;
    if (wrLog.size() != 0 || rdLog.size() != 0 || doneLog.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL areset_strobes: got wr=%0d rd=%0d done=%0d expected 0 0 0",
               wrLog.size(), rdLog.size(), doneLog.size());
    end
  endtask

  initial begin
    rstL = 1'b0;
    csN = 1'b1;
    rxDv = 1'b0;
    rxByte = 8'h00;
    @(negedge clock);
    test_reset();
    test_write();
    test_read();
    test_wrap();
    test_cmd_only();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
